window_gen: RTL and testbench
=============================

// Module: window_gen
// PURPOSE
// - Upstream feeder of the coprocessor processing element: streams one 12-bit RGB444 image from pixel RAM in raster order.
// - Builds the 3x3 neighbourhood for every pixel and presents it as three 36-bit rows: rgb_out0 = y-1, rgb_out1 = y, rgb_out2 = y+1.
// - Generates the start / cnt_start / done control pulses that the processing element consumes.
// PARAMETERS
// - IMG_W   default 320   image width in pixels, >= 2
// - IMG_H   default 240   image height in pixels, >= 2
// - ADDR_W  default $clog2(IMG_W*IMG_H)   pixel RAM address width
// PORTS
// - clk        in   1       single clock; all logic on posedge
// - rst        in   1       synchronous, active-high reset
// - go         in   1       1-cycle frame request; ignored unless IDLE
// - rd_en      out  1       pixel RAM read strobe
// - rd_addr    out  ADDR_W  raster address y*IMG_W+x
// - rd_data    in   12      RAM data; valid exactly 1 cycle after rd_en
// - rgb_out0   out  36      row y-1 window: [35:24]=x-1, [23:12]=x, [11:0]=x+1
// - rgb_out1   out  36      row y window, same packing
// - rgb_out2   out  36      row y+1 window, same packing
// - win_vld    out  1       rgb_out* hold a valid window this cycle
// - start      out  1       1-cycle pulse when go is accepted
// - cnt_start  out  1       1-cycle pulse, coincident with the first win_vld
// - done       out  1       1-cycle pulse, 1 cycle after the last win_vld
// - busy       out  1       high from go acceptance through the done cycle
// BEHAVIOUR
// - Reset: FSM=IDLE; all outputs 0; counters cleared. Reset mid-frame aborts the frame with no done pulse.
// - FSM: IDLE -go-> FILL (IMG_W+1 reads, no windows) -> RUN (read+emit per cycle) -> FLUSH (IMG_W+1 emit-only cycles, rd_en=0) -> FIN (done=1) -> IDLE.
// - Timing, with go sampled at cycle 0:
//   - start=1 at cycle 1.
//   - Address k is driven at cycle 1+k, for k = 0..IMG_W*IMG_H-1; rd_en is contiguous.
//   - Window for raster centre n is on the outputs at cycle IMG_W+4+n.
//   - win_vld is contiguous for exactly IMG_W*IMG_H cycles.
//   - done=1 at cycle IMG_W*IMG_H+IMG_W+4; busy drops the next cycle.
// - Storage: two IMG_W-deep 12-bit delay lines hold rows y-1 and y. A 3x3 column shift register is fed by {delay line 1, delay line 0, rd_data}.
// - Edges (default): out-of-image taps replicate the nearest in-image pixel.
//   - Left/right: column clamp at x=0 and x=IMG_W-1; the row wrap must not leak the previous row's pixels.
//   - Top/bottom: row clamp at y=0 and y=IMG_H-1.
// - go while busy: ignored. go together with rst: rst wins.
// - Outputs are registered. When win_vld=0, rgb_out* hold their last value.
// CONFIGURATION
// - WIN_ZERO_PAD_EN defined: out-of-image taps read 12'h000 instead of replicating. Timing is identical.
// - WIN_ZERO_PAD_EN undefined: edge replication as above.
// STRUCTURE
// - coproc_pkg holds: PIX_W=12, ROW_W=36, and typedef enum {IDLE,FILL,RUN,FLUSH,FIN} wg_state_t.
// - Sub-module line_buffer (params DEPTH, WIDTH): circular single-port RAM delay line, pointer wraps at DEPTH-1. Two instances.
// - Top holds the FSM, x/y/address counters, column shift register and edge muxing.
// TESTING
// - All scenarios use IMG_W=4, IMG_H=3, RAM model with data = address.
// - 1) go at cycle 0 -> start at cycle 1; first win_vld at cycle 8; 12 contiguous win_vld; cnt_start at cycle 8; done at cycle 20; busy low at cycle 21.
// - 2) Replicate, centre (0,0) -> rgb_out0=36'h000000001, rgb_out1=36'h000000001, rgb_out2=36'h004004005.
// - 3) Interior centre (1,1) -> rgb_out0=36'h000001002, rgb_out1=36'h004005006, rgb_out2=36'h008009
//      00A (one value: 36'h00800900A).
// - 4) WIN_ZERO_PAD_EN, centre (3,2) -> rgb_out0=36'h006007000, rgb_out1=36'h00A00B000, rgb_out2=36'h000000000.
// - 5) Second go at cycle 10 -> ignored: no extra start pulse, addresses unchanged, single done pulse at cycle 20.
// - 6) rst high at cycle 12 -> next cycle: all outputs 0 and IDLE, no done pulse; a new go reproduces scenario 1 timing.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor window generator.
// Pixel and row widths, plus the window_gen FSM state encoding.
package coproc_pkg;
  localparam int PIX_W = 12;
  localparam int ROW_W = 36;

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, FIN} wg_state_t;

  // One window row: [35:24]=x-1, [23:12]=x, [11:0]=x+1
  function automatic logic [ROW_W-1:0] pack_row(input logic [PIX_W-1:0] l,
                                                input logic [PIX_W-1:0] c,
                                                input logic [PIX_W-1:0] r);
    return {l, c, r};
  endfunction
endpackage

// File: rtl/window_gen_if.sv
// Bus between window_gen and its environment: frame request, pixel RAM read port,
// window outputs and control pulses.
interface window_gen_if import coproc_pkg::*; #(
  parameter int ADDR_W = 17
) ();
  // go is a 1-cycle request honoured only when idle; rd_data must carry the word
  // at rd_addr exactly one cycle after rd_en; rgb_out* are meaningful only while
  // win_vld=1 and hold their last value otherwise.
  logic              go;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [ROW_W-1:0]  rgb_out0;
  logic [ROW_W-1:0]  rgb_out1;
  logic [ROW_W-1:0]  rgb_out2;
  logic              win_vld;
  logic              start;
  logic              cnt_start;
  logic              done;
  logic              busy;

  modport master (
    input  go, rd_data,
    output rd_en, rd_addr, rgb_out0, rgb_out1, rgb_out2,
           win_vld, start, cnt_start, done, busy
  );

  modport slave (
    output go, rd_data,
    input  rd_en, rd_addr, rgb_out0, rgb_out1, rgb_out2,
           win_vld, start, cnt_start, done, busy
  );
endinterface

// File: rtl/line_buffer.sv
// Circular single-port delay line: dout is the word written DEPTH enabled cycles ago.
module line_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;

  // Read-before-write at the same slot gives the DEPTH-cycle delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end
endmodule

// File: rtl/window_gen.sv
// Raster pixel streamer building 3x3 neighbourhoods with edge handling.
// Define WIN_ZERO_PAD_EN for zero padding at image borders; default replicates edges.
module window_gen import coproc_pkg::*; #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic      clk,
  input  logic      rst,
  window_gen_if.master bus,
  output wg_state_t dbg_state
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] FILL_LAST  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] RUN_LAST   = ADDR_W'(NPIX - IMG_W - 2);
  localparam logic [ADDR_W-1:0] FLUSH_LAST = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] FIN_LAST   = ADDR_W'(2);

`ifdef WIN_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  wg_state_t         state, next_state;
  logic [ADDR_W-1:0] cnt;
  logic              start_d, done_d, rd_d;
  logic              emit_q;
  logic [XW-1:0]     cx;
  logic [YW-1:0]     cy;
  logic [PIX_W-1:0]  dl0, dl1;

  // Column index 2 = row y-1, 1 = row y, 0 = row y+1.
  logic [2:0][PIX_W-1:0] col_in, col_a, col_b;
  logic [2:0][PIX_W-1:0] tap_l, tap_c, tap_r;

  assign dbg_state = state;
  assign col_in    = {dl1, dl0, bus.rd_data};

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk(clk), .rst(rst), .en(1'b1), .din(bus.rd_data), .dout(dl0)
  );
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk(clk), .rst(rst), .en(1'b1), .din(dl0), .dout(dl1)
  );

  // State names follow the read side; windows trail reads by two cycles, which
  // FIN absorbs before done.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.go)            next_state = FILL;
      FILL:    if (cnt == FILL_LAST)  next_state = RUN;
      RUN:     if (cnt == RUN_LAST)   next_state = FLUSH;
      FLUSH:   if (cnt == FLUSH_LAST) next_state = FIN;
      FIN:     if (cnt == FIN_LAST)   next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
    start_d = (state == IDLE) && bus.go;
    done_d  = (state == FIN) && (cnt == ADDR_W'(1));
    rd_d    = (next_state == FILL) || (next_state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= (next_state != state || next_state == IDLE) ? '0 : cnt + 1'b1;
    end
  end

  // Out-of-image taps: row clamp first, then column clamp, so corners follow.
  always_comb begin
    tap_l = col_b;
    tap_c = col_a;
    tap_r = col_in;
    if (cy == '0) begin
      tap_l[2] = ZERO_PAD ? '0 : tap_l[1];
      tap_c[2] = ZERO_PAD ? '0 : tap_c[1];
      tap_r[2] = ZERO_PAD ? '0 : tap_r[1];
    end
    if (cy == YW'(IMG_H - 1)) begin
      tap_l[0] = ZERO_PAD ? '0 : tap_l[1];
      tap_c[0] = ZERO_PAD ? '0 : tap_c[1];
      tap_r[0] = ZERO_PAD ? '0 : tap_r[1];
    end
    if (cx == '0)              tap_l = ZERO_PAD ? '0 : tap_c;
    if (cx == XW'(IMG_W - 1))  tap_r = ZERO_PAD ? '0 : tap_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.start     <= 1'b0;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.win_vld   <= 1'b0;
      bus.cnt_start <= 1'b0;
      bus.rgb_out0  <= '0;
      bus.rgb_out1  <= '0;
      bus.rgb_out2  <= '0;
      emit_q        <= 1'b0;
      cx            <= '0;
      cy            <= '0;
      col_a         <= '0;
      col_b         <= '0;
    end else begin
      bus.start     <= start_d;
      bus.done      <= done_d;
      bus.busy      <= (next_state != IDLE);
      bus.rd_en     <= rd_d;
      if (start_d)   bus.rd_addr <= '0;
      else if (rd_d) bus.rd_addr <= bus.rd_addr + 1'b1;
      emit_q        <= (state == RUN) || (state == FLUSH);
      col_b         <= col_a;
      col_a         <= col_in;
      bus.win_vld   <= emit_q;
      bus.cnt_start <= emit_q && (cx == '0) && (cy == '0);
      if (start_d) begin
        cx <= '0;
        cy <= '0;
      end else if (emit_q) begin
        bus.rgb_out0 <= pack_row(tap_l[2], tap_c[2], tap_r[2]);
        bus.rgb_out1 <= pack_row(tap_l[1], tap_c[1], tap_r[1]);
        bus.rgb_out2 <= pack_row(tap_l[0], tap_c[0], tap_r[0]);
        if (cx == XW'(IMG_W - 1)) begin
          cx <= '0;
          cy <= (cy == YW'(IMG_H - 1)) ? '0 : cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen on a 4x3 image with a 1-cycle-latency RAM model.
// Honours WIN_ZERO_PAD_EN in its reference model and table.
module tb_window_gen;
  import coproc_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);
  localparam int LAST_CYC = N + W + 6;

  typedef struct {
    int               cx;
    int               cy;
    logic [ROW_W-1:0] e0;
    logic [ROW_W-1:0] e1;
    logic [ROW_W-1:0] e2;
  } vec_t;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  wg_state_t dbg_state;

  window_gen_if #(.ADDR_W(AW)) bus ();

  window_gen #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  logic [PIX_W-1:0] mem [N];
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [3*ROW_W-1:0] exp_q[$];
  logic [3*ROW_W-1:0] got_win [N];
  vec_t vecs [4];

  task automatic check(input string name, input logic [3*ROW_W-1:0] act,
                       input logic [3*ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: neighbourhood straight from the image array.
  function automatic logic [PIX_W-1:0] ref_pix(int x, int y);
`ifdef WIN_ZERO_PAD_EN
    if (x < 0 || x >= W || y < 0 || y >= H) return '0;
`else
    if (x < 0) x = 0;
    if (x >= W) x = W - 1;
    if (y < 0) y = 0;
    if (y >= H) y = H - 1;
`endif
    return mem[y * W + x];
  endfunction

  function automatic logic [3*ROW_W-1:0] ref_win(int n);
    logic [3*ROW_W-1:0] r = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        r = {r[3*ROW_W-PIX_W-1:0], ref_pix(n % W + dx, n / W + dy)};
    return r;
  endfunction

  // Driver: go at cycle 0, then check every cycle against the fixed timeline.
  task automatic run_frame(input int extra_go, input string tag);
    logic [3*ROW_W-1:0] e;
    exp_q.delete();
    for (int n = 0; n < N; n++) exp_q.push_back(ref_win(n));
    @(negedge clk);
    bus.go = 1'b1;
    for (int c = 1; c <= LAST_CYC; c++) begin
      @(negedge clk);
      bus.go = (c == extra_go);
      check($sformatf("%s start c%0d", tag, c), 108'(bus.start), 108'(c == 1));
      check($sformatf("%s rd_en c%0d", tag, c), 108'(bus.rd_en), 108'(c >= 1 && c <= N));
      if (c >= 1 && c <= N)
        check($sformatf("%s rd_addr c%0d", tag, c), 108'(bus.rd_addr), 108'(c - 1));
      check($sformatf("%s win_vld c%0d", tag, c), 108'(bus.win_vld),
            108'(c >= W + 4 && c < W + 4 + N));
      if (c >= W + 4 && c < W + 4 + N) begin
        e = exp_q.pop_front();
        got_win[c - W - 4] = {bus.rgb_out0, bus.rgb_out1, bus.rgb_out2};
        check($sformatf("%s window n%0d", tag, c - W - 4), got_win[c - W - 4], e);
      end
      check($sformatf("%s cnt_start c%0d", tag, c), 108'(bus.cnt_start), 108'(c == W + 4));
      check($sformatf("%s done c%0d", tag, c), 108'(bus.done), 108'(c == N + W + 4));
      check($sformatf("%s busy c%0d", tag, c), 108'(bus.busy), 108'(c <= N + W + 4));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " rd_en"},     108'(bus.rd_en),     '0);
    check({tag, " rd_addr"},   108'(bus.rd_addr),   '0);
    check({tag, " rgb"},       {bus.rgb_out0, bus.rgb_out1, bus.rgb_out2}, '0);
    check({tag, " win_vld"},   108'(bus.win_vld),   '0);
    check({tag, " start"},     108'(bus.start),     '0);
    check({tag, " cnt_start"}, 108'(bus.cnt_start), '0);
    check({tag, " done"},      108'(bus.done),      '0);
    check({tag, " busy"},      108'(bus.busy),      '0);
    check({tag, " state"},     108'(dbg_state),     108'(IDLE));
  endtask

  initial begin
    bus.go      = 1'b0;
    bus.rd_data = '0;
    for (int i = 0; i < N; i++) mem[i] = PIX_W'(i);

`ifdef WIN_ZERO_PAD_EN
    vecs[0] = '{0, 0, 36'h000000000, 36'h000000001, 36'h000004005};
    vecs[1] = '{1, 1, 36'h000001002, 36'h004005006, 36'h00800900A};
    vecs[2] = '{3, 2, 36'h006007000, 36'h00A00B000, 36'h000000000};
    vecs[3] = '{3, 0, 36'h000000000, 36'h002003000, 36'h006007000};
`else
    vecs[0] = '{0, 0, 36'h000000001, 36'h000000001, 36'h004004005};
    vecs[1] = '{1, 1, 36'h000001002, 36'h004005006, 36'h00800900A};
    vecs[2] = '{3, 2, 36'h006007007, 36'h00A00B00B, 36'h00A00B00B};
    vecs[3] = '{3, 0, 36'h002003003, 36'h002003003, 36'h006007007};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    run_frame(0, "s1");
    for (int i = 0; i < 4; i++)
      check($sformatf("table (%0d,%0d)", vecs[i].cx, vecs[i].cy),
            got_win[vecs[i].cy * W + vecs[i].cx], {vecs[i].e0, vecs[i].e1, vecs[i].e2});

    run_frame(10, "s5");

    // Reset at cycle 12 aborts the frame; no done may follow.
    @(negedge clk);
    bus.go = 1'b1;
    for (int c = 1; c <= LAST_CYC; c++) begin
      @(negedge clk);
      bus.go = 1'b0;
      if (c == 13) begin
        check_idle_outputs("abort");
        rst = 1'b0;
      end else if (c > 13) begin
        check($sformatf("abort done c%0d", c), 108'(bus.done), '0);
        check($sformatf("abort win_vld c%0d", c), 108'(bus.win_vld), '0);
      end
      if (c == 12) rst = 1'b1;
    end
    run_frame(0, "s6");

    // Random image content, random gaps and stray go pulses while busy.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) mem[i] = PIX_W'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, N + W + 4)) : 0,
                $sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
